// File: rtl/bn_pkg.sv
// Shared constants and helpers for the base-N counter family.
package bn_pkg;

   localparam int BASE_MAX   = 16;
   localparam int DIGITS_MAX = 8;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bn_digit.sv
// One radix-BASE digit of the cascaded counter: load, step up/down, and the
// carry/borrow into the next digit.
module bn_digit
   import bn_pkg::*;
#(
   parameter  int BASE = 5,
   localparam int W    = clog2(BASE)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   input  logic         up_i,
   input  logic         cin_i,
   output logic [W-1:0] q_o,
   output logic         max_o,
   output logic         min_o,
   output logic         cout_o
);

   localparam logic [W-1:0] TOP = W'(BASE - 1);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;
   logic [W-1:0] ld_val;

   assign max_o  = (q_q == TOP);
   assign min_o  = (q_q == '0);
   assign cout_o = cin_i & ((up_i == DIR_UP) ? max_o : min_o);

   // Out-of-range load digits are forced to zero so the digit never leaves 0..BASE-1.
   assign ld_val = (int'(d_i) < BASE) ? d_i : '0;

   // NOTE: combinational blocks use blocking '=' and assign q_d a default first,
   // so every path drives it and no latch is inferred.
   always_comb begin
      q_d = q_q;
      if (ld_i) begin
         q_d = ld_val;
      end else if (cin_i) begin
         if (up_i == DIR_UP) q_d = max_o ? '0 : q_q + 1'b1;
         else                q_d = min_o ? TOP : q_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking '<=' and clear on the async reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/bn_counter.sv
// Multi-digit base-N up/down counter with parallel load, optional saturation,
// combinational terminal count and a registered wrap pulse.
module bn_counter
   import bn_pkg::*;
#(
   parameter  int BASE   = 5,
   parameter  int DIGITS = 2,
   parameter  int SAT    = 0,
   localparam int W      = clog2(BASE)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              UP,
   input  logic              LD,
   input  logic [DIGITS*W-1:0] D,
   output logic [DIGITS*W-1:0] Q,
   output logic              TC,
   output logic              WRAP
);

   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] dig_max;
   logic [DIGITS-1:0] dig_min;
   logic              at_max;
   logic              at_min;
   logic              sat_hold;
   logic              wrap_d;
   logic              wrap_q;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bn_digit #(.BASE(BASE)) u_digit (
         .clk_i  (CLK),
         .rst_i  (RST),
         .ld_i   (LD),
         .d_i    (D[k*W +: W]),
         .up_i   (UP),
         .cin_i  (carry[k]),
         .q_o    (Q[k*W +: W]),
         .max_o  (dig_max[k]),
         .min_o  (dig_min[k]),
         .cout_o (carry[k+1])
      );
   end

   assign at_max = &dig_max;
   assign at_min = &dig_min;

   assign TC = EN & (((UP == DIR_UP) & at_max) | ((UP == DIR_DN) & at_min));

   // Saturation simply withholds the step at the range ends, so no carry ever
   // leaves the top digit and WRAP stays low.
   assign sat_hold = (SAT != 0) & TC;
   assign carry[0] = EN & ~sat_hold;

   assign wrap_d = ~LD & carry[DIGITS];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) wrap_q <= 1'b0;
      else     wrap_q <= wrap_d;
   end

   assign WRAP = wrap_q;

endmodule
